// File: rtl/aes32_dsp_shiftrows_fb_ctl.sv
// AES ShiftRows / InvShiftRows on a column-serial 32-bit stream.
// Four columns are gathered into a 4x4 byte buffer (FILL), then the
// permuted columns are emitted one per output handshake (EMIT).
module aes32_dsp_shiftrows_fb_ctl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IN_MODE,
  output logic [31:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_LAST
);

  typedef enum logic [0:0] {
    StFill,
    StEmit
  } state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        mode_q;
  logic [31:0] col_q [4];
  logic        in_fire;
  logic [1:0]  src_idx;
  logic [31:0] out_data;

  // Input handshake only counts while gathering and out of reset.
  assign in_fire = (state_q == StFill) && IN_VALID && !RST;

  // Phase/counter control; mode is captured with column 0 and held for the block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StFill;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (IN_VALID) begin
            if (cnt_q == 2'd0) mode_q <= IN_MODE;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= StEmit;
          end
        end
        StEmit: begin
          if (OUT_READY) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  // Column buffer; unreset because it is always rewritten before it is emitted.
  always_ff @(posedge CLK) begin
    if (in_fire) col_q[cnt_q] <= IN_DATA;
  end

  // Row r of output column j comes from buffer column j+r (forward) or j-r (inverse), mod 4.
  always_comb begin
    out_data = 32'h0;
    src_idx  = 2'd0;
    if (state_q == StEmit) begin
      for (int r = 0; r < 4; r++) begin
        src_idx = mode_q ? (cnt_q - 2'(r)) : (cnt_q + 2'(r));
        out_data[31-8*r -: 8] = col_q[src_idx][31-8*r -: 8];
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    IN_READY  = (state_q == StFill);
    OUT_VALID = (state_q == StEmit);
    OUT_LAST  = (state_q == StEmit) && (cnt_q == 2'd3);
    OUT_DATA  = out_data;
  end

endmodule
